// File: rtl/fan_current_aggregator_if.sv
// fan_current_aggregator_if: icebus current channels in, filtered per-fan currents and status out
interface fan_current_aggregator_if #(
  parameter int NUM_IN = 8,
  parameter int NUM_OUT = 6
);
  logic enable;
  logic clear_overrun;
  logic [NUM_IN*32-1:0] current_in;
  logic [NUM_OUT*32-1:0] current_out;
  logic update_strobe;
  logic overrun;
  modport master (
    output enable, clear_overrun, current_in,
    input current_out, update_strobe, overrun
  );
  modport slave (
    input enable, clear_overrun, current_in,
    output current_out, update_strobe, overrun
  );
endinterface

// File: rtl/fan_current_aggregator.sv
// fan_current_aggregator: periodic max-of-subset scan of motor currents, IIR-smoothed per fan
module fan_current_aggregator #(
  parameter int NUM_IN = 8,
  parameter int NUM_OUT = 6,
  parameter logic [NUM_OUT*NUM_IN-1:0] FAN_MAP = {6{8'h03}},
  parameter int SAMPLE_DIV = 50000,
  parameter int IIR_SHIFT = 3
) (
  input logic clk_clk,
  input logic reset_reset_n,
  fan_current_aggregator_if.slave bus
);
  localparam int CW = $clog2(SAMPLE_DIV);
  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic tick;
  logic strobe;
  logic ovr;
  logic [31:0] ch;
  assign tick = bus.enable && cnt == CW'(SAMPLE_DIV - 1);
  assign ch = bus.current_in[{idx, 5'd0} +: 32];
  assign bus.update_strobe = strobe;
  assign bus.overrun = ovr;
  // state register
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) state <= IDLE;
    else state <= state_nxt;
  // scan sequencing: wait for a tick, walk all channels, then one filter update cycle
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = tick ? SCAN : IDLE;
    else if (state == SCAN) state_nxt = idx == 3'(NUM_IN - 1) ? UPDATE : SCAN;
    else state_nxt = IDLE;
  end
  // divider, channel index, update pulse and sticky overrun (clear beats a simultaneous set)
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      cnt <= '0;
      idx <= '0;
      strobe <= 1'b0;
      ovr <= 1'b0;
    end else begin
      cnt <= (!bus.enable || tick) ? '0 : cnt + 1'b1;
      idx <= state == SCAN ? idx + 1'b1 : '0;
      strobe <= state == UPDATE;
      ovr <= bus.clear_overrun ? 1'b0 : (tick && state != IDLE) ? 1'b1 : ovr;
    end
  for (genvar o = 0; o < NUM_OUT; o++) begin : g_fan
    localparam logic [NUM_IN-1:0] MAP_ROW = FAN_MAP[o*NUM_IN +: NUM_IN];
    logic [31:0] mx;
    logic [31:0] out_q;
    logic [31:0] d;
    logic [31:0] step;
    logic [31:0] nxt;
    assign d = mx > out_q ? mx - out_q : out_q - mx;
    assign step = (d != 0 && (d >> IIR_SHIFT) == 0) ? 32'd1 : d >> IIR_SHIFT;
    assign nxt = mx > out_q ? out_q + step : mx < out_q ? out_q - step : out_q;
    assign bus.current_out[o*32 +: 32] = out_q;
    // running max over mapped channels, then a single bounded step toward it
    always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
        mx <= '0;
        out_q <= '0;
      end else begin
        if (state == IDLE && tick) mx <= '0;
        else if (state == SCAN && MAP_ROW[idx] && ch > mx) mx <= ch;
        if (state == UPDATE) out_q <= nxt;
      end
  end
endmodule

// File: tb/tb_fan_current_aggregator.sv
// tb_fan_current_aggregator: directed checks of scan timing, max mapping, IIR steps, overrun, reset
module tb_fan_current_aggregator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [2:0] strb;
  always #5 clk = ~clk;
  fan_current_aggregator_if #(.NUM_IN(8), .NUM_OUT(6)) ia ();
  fan_current_aggregator_if #(.NUM_IN(8), .NUM_OUT(6)) ib ();
  fan_current_aggregator_if #(.NUM_IN(8), .NUM_OUT(6)) ic ();
  fan_current_aggregator #(
    .SAMPLE_DIV(20), .IIR_SHIFT(0),
    .FAN_MAP({8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h03})
  ) dut_a (.clk_clk(clk), .reset_reset_n(rst_n), .bus(ia.slave));
  fan_current_aggregator #(
    .SAMPLE_DIV(20), .IIR_SHIFT(3),
    .FAN_MAP({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01})
  ) dut_b (.clk_clk(clk), .reset_reset_n(rst_n), .bus(ib.slave));
  fan_current_aggregator #(
    .SAMPLE_DIV(5), .IIR_SHIFT(0)
  ) dut_c (.clk_clk(clk), .reset_reset_n(rst_n), .bus(ic.slave));
  assign strb = {ic.update_strobe, ib.update_strobe, ia.update_strobe};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  task automatic wait_strobe(input int k, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!strb[k] && n < budget);
    if (!strb[k]) chk("strobe_timeout", 32'd0, 32'd1);
  endtask
  function automatic logic [31:0] iir(input logic [31:0] o, input logic [31:0] m, input int sh);
    logic [31:0] d, s;
    d = m > o ? m - o : o - m;
    s = d >> sh;
    if (d != 0 && s == 0) s = 1;
    return m > o ? o + s : m < o ? o - s : o;
  endfunction
  initial begin
    int n;
    logic [31:0] e;
    logic [31:0] rise [3] = '{32'd100, 32'd187, 32'd263};
    logic [31:0] fall [2] = '{32'd700, 32'd613};
    ia.enable = 0; ia.clear_overrun = 0; ia.current_in = '0;
    ib.enable = 0; ib.clear_overrun = 0; ib.current_in = '0;
    ic.enable = 0; ic.clear_overrun = 0; ic.current_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_out0", ia.current_out[31:0], 0);
    chk("rst_a_strobe", 32'(ia.update_strobe), 0);
    chk("rst_c_overrun", 32'(ic.overrun), 0);
    rst_n = 1;
    @(negedge clk);
    ia.current_in[0 +: 32] = 100;
    ia.current_in[32 +: 32] = 300;
    ia.enable = 1;
    wait_strobe(0, 40, n);
    chk("a_latency", n, 29);
    chk("a_fan0_max", ia.current_out[0 +: 32], 300);
    chk("a_fan1_all", ia.current_out[32 +: 32], 300);
    chk("a_fan2_unmapped", ia.current_out[64 +: 32], 0);
    chk("a_fan5_unmapped", ia.current_out[160 +: 32], 0);
    @(negedge clk);
    chk("a_strobe_width", 32'(ia.update_strobe), 0);
    wait_strobe(0, 40, n);
    chk("a_period", n, 19);
    ia.current_in = '1;
    wait_strobe(0, 25, n);
    chk("a_fan0_ffff", ia.current_out[0 +: 32], 32'hFFFF_FFFF);
    chk("a_fan1_ffff", ia.current_out[32 +: 32], 32'hFFFF_FFFF);
    chk("a_fan2_ffff", ia.current_out[64 +: 32], 0);
    ia.current_in = '0;
    wait_strobe(0, 25, n);
    chk("a_fan0_drop", ia.current_out[0 +: 32], 0);
    chk("a_fan1_drop", ia.current_out[32 +: 32], 0);
    repeat (13) @(negedge clk);
    ia.enable = 0;
    wait_strobe(0, 20, n);
    chk("a_finish_after_disable", n, 7);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      n += int'(ia.update_strobe);
    end
    chk("a_no_strobe_disabled", n, 0);
    ia.current_in[32 +: 32] = 55;
    ia.enable = 1;
    wait_strobe(0, 40, n);
    chk("a_reenable_latency", n, 29);
    chk("a_fan0_reenable", ia.current_out[0 +: 32], 55);
    ib.current_in[0 +: 32] = 800;
    ib.enable = 1;
    e = 0;
    for (int i = 0; i < 50; i++) begin
      wait_strobe(1, 40, n);
      e = iir(e, 800, 3);
      chk("b_rise", ib.current_out[0 +: 32], e);
      if (i < 3) chk("b_rise_hand", ib.current_out[0 +: 32], rise[i]);
    end
    chk("b_rise_final", ib.current_out[0 +: 32], 800);
    chk("b_fan1_unmapped", ib.current_out[32 +: 32], 0);
    ib.current_in[0 +: 32] = 0;
    for (int i = 0; i < 50; i++) begin
      wait_strobe(1, 40, n);
      e = iir(e, 0, 3);
      chk("b_fall", ib.current_out[0 +: 32], e);
      if (i < 2) chk("b_fall_hand", ib.current_out[0 +: 32], fall[i]);
    end
    chk("b_fall_final", ib.current_out[0 +: 32], 0);
    ib.enable = 0;
    chk("c_overrun_idle", 32'(ic.overrun), 0);
    ic.current_in[32 +: 32] = 9;
    ic.enable = 1;
    wait_strobe(2, 30, n);
    chk("c_fan3_value", ic.current_out[96 +: 32], 9);
    chk("c_overrun_set", 32'(ic.overrun), 1);
    ic.enable = 0;
    repeat (15) @(negedge clk);
    chk("c_overrun_sticky", 32'(ic.overrun), 1);
    ic.clear_overrun = 1;
    @(negedge clk);
    ic.clear_overrun = 0;
    chk("c_overrun_clear", 32'(ic.overrun), 0);
    ic.clear_overrun = 1;
    ic.enable = 1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      n += int'(ic.overrun);
    end
    chk("c_clear_wins", n, 0);
    ic.clear_overrun = 0;
    repeat (12) @(negedge clk);
    chk("c_overrun_reset_after_clear", 32'(ic.overrun), 1);
    wait_strobe(0, 25, n);
    repeat (14) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_a_out0", ia.current_out[0 +: 32], 0);
    chk("async_a_out1", ia.current_out[32 +: 32], 0);
    chk("async_a_strobe", 32'(ia.update_strobe), 0);
    chk("async_c_overrun", 32'(ic.overrun), 0);
    chk("async_c_out3", ic.current_out[96 +: 32], 0);
    ia.enable = 0;
    ic.enable = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      n += int'(|strb);
    end
    chk("async_no_strobe", n, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
